ldl_bin2hot_v2: RTL

Registered, flow-controlled successor to the combinational binary-to-one-hot decoder. Accepts a binary index over a valid/ready input channel and returns a decoded vector over a valid/ready output channel. Selectable modes: one-hot, thermometer, one-cold, and sticky accumulate. Supports output widths that are not a power of two and flags out-of-range indices. Used wherever the datapath needs a select vector or request mask built from an index stream.

---
 rtl/ldl_bin2hot_v2_pkg.sv | 37 +++
 rtl/ldl_bin2hot_v2_skid_buf.sv | 56 +++++
 rtl/ldl_bin2hot_v2.sv | 114 +++++++++++
 3 files changed

// File: rtl/ldl_bin2hot_v2_pkg.sv
// Shared types and helpers for the flow-controlled binary-to-vector decoder.
// Holds the mode encoding and the per-bit decode rule used by ldl_bin2hot_v2.
package ldl_bin2hot_pkg;

    // Decode modes, matching the 2-bit in_mode encoding on the top-level port.
    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'd0,
        MODE_THERMO  = 2'd1,
        MODE_ONECOLD = 2'd2,
        MODE_ACCUM   = 2'd3
    } mode_e;

    // Widest index the decoder is meant to be built with.
    localparam int MAX_BIN_WIDTH = 8;

    // Value of output bit idx for index x. An out-of-range x never equals
    // and always exceeds every legal idx. That gives 0 for one-hot, all ones
    // for thermometer and one-cold, and an unchanged accumulator, with no
    // special-case logic.
    function automatic logic decode_bit(
        input mode_e       mode,
        input logic [31:0] idx,
        input logic [31:0] x,
        input logic        acc_bit
    );
        logic bit_val;
        case (mode)
            MODE_ONEHOT:  bit_val = (idx == x);
            MODE_THERMO:  bit_val = (idx <= x);
            MODE_ONECOLD: bit_val = (idx != x);
            MODE_ACCUM:   bit_val = acc_bit | (idx == x);
            default:      bit_val = 1'b0;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/ldl_bin2hot_v2_skid_buf.sv
// Generic 2-entry valid/ready skid register.
// The main entry drives the downstream side. The skid entry catches the one
// beat that was accepted in the same cycle the downstream stalled. up_ready
// comes straight from a flop, so upstream sees no combinational path from
// dn_ready.
module ldl_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] dn_data
);

    logic                  main_valid_q;
    logic [DATA_WIDTH-1:0] main_data_q;
    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic                  up_fire;

    assign up_ready = ~skid_valid_q;
    assign up_fire  = up_valid & up_ready;
    assign dn_valid = main_valid_q;
    assign dn_data  = main_data_q;

    // When the main entry is free or draining, refill it from the skid entry
    // first (to keep order), otherwise from upstream. When it is stalled, park
    // the incoming beat in the skid entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (!main_valid_q || dn_ready) begin
            if (skid_valid_q) begin
                main_data_q  <= skid_data_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (up_fire) begin
                main_data_q  <= up_data;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (up_fire) begin
            skid_data_q  <= up_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ldl_bin2hot_v2.sv
// Registered, valid/ready binary-to-vector decoder.
// Modes are one-hot, thermometer, one-cold and sticky accumulate.
// out_err flags an index that does not fit in OUT_WIDTH.
// Build option LDL_BIN2HOT_V2_SKID_EN adds a 2-entry skid buffer in front of
// the output, so in_ready is registered. Without it there is a single output
// register, and in_ready depends combinationally on out_ready.
module ldl_bin2hot_v2
    import ldl_bin2hot_pkg::*;
#(
    parameter int BIN_WIDTH = 4,
    parameter int OUT_WIDTH = 1 << BIN_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] in_x,
    input  logic [1:0]           in_mode,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_y,
    output logic                 out_err,
    output logic [OUT_WIDTH-1:0] acc_y
);

    mode_e                mode_in;
    logic [31:0]          x_ext;
    logic                 in_fire;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0] acc_base;
    logic [OUT_WIDTH-1:0] dec_y;
    logic                 dec_err;

    assign mode_in = mode_e'(in_mode);
    assign x_ext   = 32'(in_x);
    assign in_fire = in_valid & in_ready;
    assign acc_y   = acc_q;

    // Decode the incoming index. A same-cycle acc_clr wipes the accumulator
    // before the new bit is OR-ed in, so clear-then-set needs no extra state.
    always_comb begin
        acc_base = acc_clr ? '0 : acc_q;
        dec_y    = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            dec_y[i] = decode_bit(mode_in, i, x_ext, acc_base[i]);
        end
        dec_err = (x_ext >= 32'(OUT_WIDTH));
    end

    // The accumulator changes only on an accepted accumulate beat or on a
    // clear. An accepted beat already carries the clear through acc_base.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (in_fire && (mode_in == MODE_ACCUM)) begin
            acc_q <= dec_y;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

`ifdef LDL_BIN2HOT_V2_SKID_EN

    logic                 skid_up_ready;
    logic [OUT_WIDTH:0]   skid_dn_data;

    ldl_skid_buf #(
        .DATA_WIDTH (OUT_WIDTH + 1)
    ) u_skid_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (in_valid),
        .up_ready (skid_up_ready),
        .up_data  ({dec_err, dec_y}),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (skid_dn_data)
    );

    assign in_ready = rst_n & skid_up_ready;
    assign out_err  = skid_dn_data[OUT_WIDTH];
    assign out_y    = skid_dn_data[OUT_WIDTH-1:0];

`else

    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_y_q;
    logic                 out_err_q;

    assign in_ready  = rst_n & (~out_valid_q | out_ready);
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_err   = out_err_q;

    // Single output register: load on accept, otherwise drop valid once the
    // held beat has been taken, and keep the payload stable while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_err_q   <= 1'b0;
        end else if (in_fire) begin
            out_valid_q <= 1'b1;
            out_y_q     <= dec_y;
            out_err_q   <= dec_err;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`endif

endmodule
